row_clear_sequencer: RTL and testbench
======================================

# row_clear_sequencer

Sequences the line-clear pass on the 10x20 game board after a piece locks. It scans every row from bottom to top and drops full rows. Non-full rows are compacted downward, and the vacated top rows are filled with empty cells. The result is the count of cleared lines. It sits between `block_logic`, which pulses `start` when a piece locks, and the board's row-wide storage port, and it drives `BOARD_BUSY` for the rest of the design.

## Interface
Parameters:
- `ROWS`, 20, board height in rows; row 0 is the top.
- `COLS`, 10, cells per row.
- `CW`, 3, bits per cell (`block_color` encoding); value 0 means an empty cell.

Ports:
- `Clk`  in  1  system clock (50 MHz).
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- `busy`  out  1  high while a pass is in progress; feeds `BOARD_BUSY`.
- `done`  out  1  one-cycle pulse when the pass completes.
- `lines_cleared`  out  $clog2(ROWS+1)  full rows removed by the last pass; held until the next accepted `start`.
- `rd_row`  out  $clog2(ROWS)  board row read address.
- `rd_data`  in  COLS*CW  row contents; valid one cycle after `rd_row` is presented (synchronous read).
- `wr_en`  out  1  board row write strobe.
- `wr_row`  out  $clog2(ROWS)  board row write address.
- `wr_data`  out  COLS*CW  row data to write.

## Operation
- Row full: all COLS fields of `CW` bits are nonzero.
- Registers:
  - `rd_ptr`: next source row.
  - `wr_ptr`: next destination row, one bit wider than `rd_row` so it can represent -1.
  - `count`: number of full rows seen.
  - `row_buf`: captured row.
- IDLE: `busy`=0. On `start`: `rd_ptr`=ROWS-1, `wr_ptr`=ROWS-1, `count`=0, `lines_cleared`=0, go to RD.
- RD: drive `rd_row`=`rd_ptr`, go to CHK.
- CHK: `rd_data` is valid this cycle.
  - Full row: `count`++.
  - Non-full row with `wr_ptr`==`rd_ptr`: `wr_ptr`--, no write.
  - Non-full row with `wr_ptr`!=`rd_ptr`: `row_buf`=`rd_data`, go to WR.
- WR: `wr_en`=1, `wr_row`=`wr_ptr`, `wr_data`=`row_buf`; then `wr_ptr`--.
- After CHK or WR, advance as follows:
  - If `rd_ptr`>0: `rd_ptr`-- and go to RD.
  - If `rd_ptr`==0 and `count`>0: go to FILL.
  - If `rd_ptr`==0 and `count`==0: go to DONE.
- FILL: `wr_en`=1, `wr_row`=`wr_ptr`, `wr_data`=0, `wr_ptr`--; after writing row 0, go to DONE. FILL writes exactly `count` rows.
- DONE: `done`=1, `lines_cleared`=`count`, go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor restarted.
- Reset asserted mid-pass:
  - State returns to IDLE immediately.
  - All outputs go to 0 and no further `wr_en` is issued.
  - The board is left in whatever state it reached; the board is reset by the same top-level reset.
- Reset values:
  - `busy`, `done`, `wr_en`, `lines_cleared`, `rd_row`, `wr_row`, `wr_data` are all 0.
  - State is IDLE.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from `rd_data` to any output.
- `start` is sampled at edge 0; `busy` rises after edge 0 (state RD) and falls when DONE exits to IDLE.
- Each row costs 2 cycles (RD, CHK), plus 1 cycle (WR) if it is copied.
- FILL costs `count` cycles.
- DONE lasts 1 cycle.
- Total cycles from `start` to `done` = 2*ROWS + copies + `count`, with `done` on the following cycle. With no clears this is 40 cycles, `done` in cycle 41.
- At most one write per cycle. `wr_en` is never high in RD or CHK.
- `lines_cleared` updates in the same cycle `done` rises.

## Test plan
- Empty board, `start` → no `wr_en` pulses; `done` 41 cycles after `start`; `lines_cleared`=0; `busy` high for exactly 41 cycles.
- Row 19 full, row 18=pattern A, rows 0-17 empty → 19 copy writes (18→19, ..., 0→1); row 19=A; row 0 written to 0; `lines_cleared`=1; `done` at cycle 61.
- Rows 16-19 full, row 15=pattern B → B lands in row 19; rows 0-3 zeroed by FILL; `lines_cleared`=4.
- Rows 19 and 17 full, row 18=A, row 16=C → A in row 19, C in row 18; rows 0-1 zero; `lines_cleared`=2.
- All 20 rows full → no copy writes; 20 FILL writes (rows 19..0 all zero); `lines_cleared`=20.
- `start` pulsed again mid-pass → ignored, with results identical to a single pass. `Reset_n` dropped during WR → `wr_en`, `busy`, `done` go low asynchronously; IDLE with `lines_cleared`=0 after release; the next `start` runs a full pass.

Source files
------------

// File: rtl/row_clear_sequencer.sv
// Line-clear pass over a row-addressed game board: scans bottom to top, drops
// full rows, compacts the rest downward and blanks the vacated top rows.
module row_clear_sequencer #(
    parameter int ROWS = 20,
    parameter int COLS = 10,
    parameter int CW   = 3
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(ROWS+1)-1:0]   lines_cleared,
    output logic [$clog2(ROWS)-1:0]     rd_row,
    input  logic [COLS*CW-1:0]          rd_data,
    output logic                        wr_en,
    output logic [$clog2(ROWS)-1:0]     wr_row,
    output logic [COLS*CW-1:0]          wr_data
);

    localparam int RW = $clog2(ROWS);
    localparam int PW = RW + 1;
    localparam int LW = $clog2(ROWS + 1);
    localparam int DW = COLS * CW;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CHK, S_WR, S_FILL, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;   // extra bit lets it reach -1
    logic [LW-1:0]   count_q, count_d;
    logic [LW-1:0]   lines_q, lines_d;
    logic [DW-1:0]   row_buf_q, row_buf_d;
    logic            row_full;
    logic            advance;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (rd_data[c*CW +: CW] == '0) row_full = 1'b0;
        end
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        lines_d   = lines_q;
        row_buf_d = row_buf_q;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_ptr_d = LAST_ROW;
                    wr_ptr_d = {1'b0, LAST_ROW};
                    count_d  = '0;
                    lines_d  = '0;
                    state_d  = S_RD;
                end
            end
            S_RD:  state_d = S_CHK;
            S_CHK: begin
                if (row_full) begin
                    count_d = count_q + 1'b1;
                    advance = 1'b1;
                end else if (wr_ptr_q == {1'b0, rd_ptr_q}) begin
                    // Row already sits at its destination: skip the write.
                    wr_ptr_d = wr_ptr_q - 1'b1;
                    advance  = 1'b1;
                end else begin
                    row_buf_d = rd_data;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                wr_ptr_d = wr_ptr_q - 1'b1;
                advance  = 1'b1;
            end
            S_FILL: begin
                wr_ptr_d = wr_ptr_q - 1'b1;
                if (wr_ptr_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (rd_ptr_q != '0) begin
                rd_ptr_d = rd_ptr_q - 1'b1;
                state_d  = S_RD;
            end else if (count_d != '0) begin
                state_d = S_FILL;
            end else begin
                state_d = S_DONE;
            end
        end

        // Publish the result on the same edge that enters DONE.
        if (state_d == S_DONE && state_q != S_DONE) lines_d = count_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            lines_q   <= '0;
            row_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            lines_q   <= lines_d;
            row_buf_q <= row_buf_d;
        end
    end

    // Outputs decode from state only, so reset forces them low asynchronously.
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign wr_en         = (state_q == S_WR) || (state_q == S_FILL);
    assign wr_row        = wr_en ? wr_ptr_q[RW-1:0] : '0;
    assign wr_data       = (state_q == S_WR) ? row_buf_q : '0;
    assign rd_row        = (state_q == S_RD) ? rd_ptr_q : '0;
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_row_clear_sequencer.sv
// Directed bench for row_clear_sequencer with a synchronous-read board model.
module tb_row_clear_sequencer;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int CW   = 3;
    localparam int RW   = $clog2(ROWS);
    localparam int LW   = $clog2(ROWS + 1);
    localparam int DW   = COLS * CW;

    localparam logic [DW-1:0] FULL  = {10{3'b101}};
    localparam logic [DW-1:0] PAT_A = {{9{3'b011}}, 3'b000};
    localparam logic [DW-1:0] PAT_B = {3'b000, {9{3'b110}}};
    localparam logic [DW-1:0] PAT_C = {{4{3'b111}}, 3'b000, {5{3'b010}}};
    localparam logic [DW-1:0] PAT_D = {3'b001, {9{3'b000}}};
    localparam logic [DW-1:0] PAT_E = {{2{3'b100}}, 3'b000, {7{3'b001}}};
    localparam logic [DW-1:0] PAT_F = {{8{3'b010}}, 3'b000, 3'b110};

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          busy, done, wr_en;
    logic [LW-1:0] lines_cleared;
    logic [RW-1:0] rd_row, wr_row;
    logic [DW-1:0] rd_data, wr_data;

    logic          ld_en;
    logic [RW-1:0] ld_row;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] board [ROWS];
    logic [DW-1:0] img   [ROWS];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #10 Clk = ~Clk;

    row_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .rd_row(rd_row), .rd_data(rd_data),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data)
    );

    // Board storage: shares the top-level reset, synchronous read.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ROWS; i++) board[i] <= '0;
            rd_data <= '0;
        end else begin
            if (ld_en) board[ld_row] <= ld_data;
            else if (wr_en) board[wr_row] <= wr_data;
            rd_data <= board[rd_row];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_img();
        for (int r = 0; r < ROWS; r++) img[r] = '0;
    endtask

    task automatic load_img();
        for (int r = 0; r < ROWS; r++) begin
            @(negedge Clk);
            ld_en = 1'b1; ld_row = RW'(r); ld_data = img[r];
        end
        @(negedge Clk);
        ld_en = 1'b0;
    endtask

    // Pulses start (sampled at edge 0) and watches cycles 1.. until done.
    task automatic run_pass(input int restart_cyc, output int done_cyc,
                            output int writes, output int busy_cyc);
        int cyc;
        done_cyc = 0; writes = 0; busy_cyc = 0;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            start = (cyc == restart_cyc);
            if (busy)  busy_cyc++;
            if (wr_en) writes++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge Clk);
            cyc++;
        end
        start = 1'b0;
        if (done_cyc == 0) chk("pass_timeout", 64'(cyc), 64'd0);
        @(negedge Clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    int dc, wc, bc, guard;
    logic [DW-1:0] acc;

    initial begin
        Reset_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_row = '0; ld_data = '0;
        #25;
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        @(negedge Clk); Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_lines",   64'(lines_cleared), 64'd0);
        chk("rst_rd_row",  64'(rd_row), 64'd0);
        chk("rst_wr_row",  64'(wr_row), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);

        // Empty board: nothing written, 40 cycles then done.
        clear_img(); load_img();
        run_pass(0, dc, wc, bc);
        chk("empty_done_cyc", 64'(dc), 64'd41);
        chk("empty_writes",   64'(wc), 64'd0);
        chk("empty_busy",     64'(bc), 64'd41);
        chk("empty_lines",    64'(lines_cleared), 64'd0);

        // Bottom row full: 19 copies + 1 fill.
        clear_img(); img[19] = FULL; img[18] = PAT_A; load_img();
        run_pass(0, dc, wc, bc);
        chk("one_done_cyc", 64'(dc), 64'd61);
        chk("one_writes",   64'(wc), 64'd20);
        chk("one_busy",     64'(bc), 64'd61);
        chk("one_lines",    64'(lines_cleared), 64'd1);
        chk("one_row19",    64'(board[19]), 64'(PAT_A));
        chk("one_row18",    64'(board[18]), 64'd0);
        chk("one_row0",     64'(board[0]), 64'd0);

        // Four full rows at the bottom.
        clear_img();
        for (int r = 16; r < 20; r++) img[r] = FULL;
        img[15] = PAT_B; img[0] = PAT_D; load_img();
        run_pass(0, dc, wc, bc);
        chk("four_done_cyc", 64'(dc), 64'd61);
        chk("four_writes",   64'(wc), 64'd20);
        chk("four_lines",    64'(lines_cleared), 64'd4);
        chk("four_row19",    64'(board[19]), 64'(PAT_B));
        chk("four_row4",     64'(board[4]), 64'(PAT_D));
        chk("four_row3",     64'(board[3]), 64'd0);
        chk("four_row0",     64'(board[0]), 64'd0);

        // Interleaved full rows.
        clear_img(); img[19] = FULL; img[18] = PAT_A; img[17] = FULL; img[16] = PAT_C;
        img[0] = PAT_D; load_img();
        run_pass(0, dc, wc, bc);
        chk("two_done_cyc", 64'(dc), 64'd61);
        chk("two_writes",   64'(wc), 64'd20);
        chk("two_lines",    64'(lines_cleared), 64'd2);
        chk("two_row19",    64'(board[19]), 64'(PAT_A));
        chk("two_row18",    64'(board[18]), 64'(PAT_C));
        chk("two_row2",     64'(board[2]), 64'(PAT_D));
        chk("two_row1",     64'(board[1]), 64'd0);
        chk("two_row0",     64'(board[0]), 64'd0);

        // Non-full bottom row stays in place without a write.
        clear_img(); img[19] = PAT_E; img[18] = FULL; img[17] = PAT_F; load_img();
        run_pass(0, dc, wc, bc);
        chk("skip_done_cyc", 64'(dc), 64'd60);
        chk("skip_writes",   64'(wc), 64'd19);
        chk("skip_lines",    64'(lines_cleared), 64'd1);
        chk("skip_row19",    64'(board[19]), 64'(PAT_E));
        chk("skip_row18",    64'(board[18]), 64'(PAT_F));
        chk("skip_row0",     64'(board[0]), 64'd0);

        // Whole board full: only fill writes.
        for (int r = 0; r < ROWS; r++) img[r] = FULL;
        load_img();
        run_pass(0, dc, wc, bc);
        acc = '0;
        for (int r = 0; r < ROWS; r++) acc = acc | board[r];
        chk("all_done_cyc", 64'(dc), 64'd61);
        chk("all_writes",   64'(wc), 64'd20);
        chk("all_lines",    64'(lines_cleared), 64'd20);
        chk("all_board_or", 64'(acc), 64'd0);

        // Second start mid-pass is ignored.
        clear_img(); img[19] = FULL; img[18] = PAT_A; load_img();
        run_pass(10, dc, wc, bc);
        chk("restart_done_cyc", 64'(dc), 64'd61);
        chk("restart_writes",   64'(wc), 64'd20);
        chk("restart_lines",    64'(lines_cleared), 64'd1);
        chk("restart_row19",    64'(board[19]), 64'(PAT_A));
        chk("restart_idle",     64'(busy), 64'd0);

        // Reset asserted during a copy write.
        clear_img(); img[19] = FULL; img[18] = PAT_A; load_img();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        guard = 0;
        while (!wr_en && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        chk("mid_wr_seen", 64'(wr_en), 64'd1);
        #3 Reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_busy",  64'(busy), 64'd0);
        chk("mid_rst_done",  64'(done), 64'd0);
        chk("mid_rst_lines", 64'(lines_cleared), 64'd0);
        @(negedge Clk); Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_busy",  64'(busy), 64'd0);
        chk("post_rst_lines", 64'(lines_cleared), 64'd0);

        clear_img(); img[19] = FULL; img[18] = PAT_A; img[17] = FULL; img[16] = PAT_C;
        load_img();
        run_pass(0, dc, wc, bc);
        chk("after_rst_done_cyc", 64'(dc), 64'd61);
        chk("after_rst_lines",    64'(lines_cleared), 64'd2);
        chk("after_rst_row18",    64'(board[18]), 64'(PAT_C));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
